// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body ring reader.
// Holds the grid/ring dimensions, the direction encoding, the walker FSM
// states and the wrap-aware backward step used to trace the body from the head.
package snake_pkg;

  localparam int unsigned DEPTH    = 220;  // slots in the direction ring
  localparam int unsigned GRID_W   = 20;   // playfield width in cells
  localparam int unsigned GRID_H   = 15;   // playfield height in cells
  localparam int unsigned X_BITS   = 5;
  localparam int unsigned Y_BITS   = 4;
  localparam int unsigned LEN_BITS = 8;

  // Slot k holds the move taken from segment k+1 to segment k.
  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,  // +x
    DIR_DOWN  = 2'd1,  // +y
    DIR_LEFT  = 2'd2,  // -x
    DIR_UP    = 2'd3   // -y
  } dir_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StWalk  = 2'd2
  } walk_state_e;

  typedef struct packed {
    logic [X_BITS-1:0] x;
    logic [Y_BITS-1:0] y;
  } coord_t;

  // Undo one move: returns the coordinate of the segment behind (x, y).
  function automatic coord_t step_back(input logic [X_BITS-1:0] x,
                                       input logic [Y_BITS-1:0] y,
                                       input dir_t              dir);
    coord_t c;
    c.x = x;
    c.y = y;
    case (dir)
      DIR_RIGHT: c.x = (x == '0) ? X_BITS'(GRID_W - 1) : x - 1'b1;
      DIR_DOWN:  c.y = (y == '0) ? Y_BITS'(GRID_H - 1) : y - 1'b1;
      DIR_LEFT:  c.x = (x == X_BITS'(GRID_W - 1)) ? '0 : x + 1'b1;
      DIR_UP:    c.y = (y == Y_BITS'(GRID_H - 1)) ? '0 : y + 1'b1;
      default:   c = c;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/snake_coord_stepper.sv
// Combinational wrap-aware coordinate decrement.
// Ports:
//   x_i, y_i : current segment coordinate
//   dir_i    : ring direction entry for this segment
//   x_o, y_o : coordinate of the next segment towards the tail
module snake_coord_stepper
  import snake_pkg::*;
(
  input  logic [X_BITS-1:0] x_i,
  input  logic [Y_BITS-1:0] y_i,
  input  logic [1:0]        dir_i,
  output logic [X_BITS-1:0] x_o,
  output logic [Y_BITS-1:0] y_o
);

  coord_t nxt;

  always_comb begin
    nxt = step_back(x_i, y_i, dir_t'(dir_i));
  end

  assign x_o = nxt.x;
  assign y_o = nxt.y;

endmodule

// File: rtl/snake_body_walker.sv
// Reader end of the snake body direction ring.
// A free-running phase counter tracks which ring slot is on i_dir. After a
// start request the walker waits for slot 0, then traces every body segment
// from the head, one per cycle, and reports whether a query cell lies on the
// body (head excluded).
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   i_start              : request one walk pass
//   i_head_x/y, i_length : head and body length, sampled at walk begin
//   i_query_x/y          : query cell, sampled at walk begin
//   i_dir                : ring output tap
//   o_phase0             : slot 0 is on i_dir this cycle
//   o_busy               : pass pending or in progress
//   o_seg_*              : registered segment stream (one cycle after tap)
//   o_hit                : query hit during the last completed pass
//   o_done               : end-of-pass pulse
module snake_body_walker
  import snake_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [X_BITS-1:0]   i_head_x,
  input  logic [Y_BITS-1:0]   i_head_y,
  input  logic [LEN_BITS-1:0] i_length,
  input  logic [X_BITS-1:0]   i_query_x,
  input  logic [Y_BITS-1:0]   i_query_y,
  input  logic [1:0]          i_dir,
  output logic                o_phase0,
  output logic                o_busy,
  output logic                o_seg_valid,
  output logic [LEN_BITS-1:0] o_seg_idx,
  output logic [X_BITS-1:0]   o_seg_x,
  output logic [Y_BITS-1:0]   o_seg_y,
  output logic                o_hit,
  output logic                o_done
);

  localparam logic [LEN_BITS-1:0] LastPhase = LEN_BITS'(DEPTH - 1);

  walk_state_e         state_q, state_d;
  logic [LEN_BITS-1:0] phase_q, phase_d;
  logic [X_BITS-1:0]   cur_x_q, cur_x_d, qry_x_q, qry_x_d;
  logic [Y_BITS-1:0]   cur_y_q, cur_y_d, qry_y_q, qry_y_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic                hit_acc_q, hit_acc_d;
  logic                done_pend_q, done_pend_d;

  logic                seg_valid_q, seg_valid_d;
  logic [LEN_BITS-1:0] seg_idx_q, seg_idx_d;
  logic [X_BITS-1:0]   seg_x_q, seg_x_d;
  logic [Y_BITS-1:0]   seg_y_q, seg_y_d;
  logic                hit_q, hit_d;
  logic                done_q, done_d;

  logic                last_phase, walking, first;
  logic [X_BITS-1:0]   base_x, step_x, eff_qx;
  logic [Y_BITS-1:0]   base_y, step_y, eff_qy;
  logic [LEN_BITS-1:0] eff_len;
  logic                seg_live, seg_hit;

  assign last_phase = (phase_q == LastPhase);
  assign walking    = (state_q == StWalk);
  // The phase-0 walk cycle consumes the head/length/query straight from the
  // inputs; later cycles use the copies latched at that edge.
  assign first      = walking && (phase_q == '0);

  assign base_x  = first ? i_head_x  : cur_x_q;
  assign base_y  = first ? i_head_y  : cur_y_q;
  assign eff_len = first ? i_length  : len_q;
  assign eff_qx  = first ? i_query_x : qry_x_q;
  assign eff_qy  = first ? i_query_y : qry_y_q;

  // phase never reaches DEPTH, so this is k < min(length, DEPTH).
  assign seg_live = (phase_q < eff_len);
  assign seg_hit  = walking && seg_live && (phase_q != '0) &&
                    (base_x == eff_qx) && (base_y == eff_qy);

  snake_coord_stepper u_stepper (
    .x_i   (base_x),
    .y_i   (base_y),
    .dir_i (i_dir),
    .x_o   (step_x),
    .y_o   (step_y)
  );

  always_comb begin
    phase_d = last_phase ? '0 : phase_q + 1'b1;

    state_d = state_q;
    unique case (state_q)
      // Starting in the last phase goes straight to the walk at phase 0.
      StIdle:  if (i_start) state_d = last_phase ? StWalk : StArmed;
      StArmed: if (last_phase) state_d = StWalk;
      StWalk:  if (last_phase) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    cur_x_d = walking ? step_x : cur_x_q;
    cur_y_d = walking ? step_y : cur_y_q;
    len_d   = first ? i_length  : len_q;
    qry_x_d = first ? i_query_x : qry_x_q;
    qry_y_d = first ? i_query_y : qry_y_q;

    hit_acc_d   = first ? 1'b0 : (hit_acc_q | seg_hit);
    done_pend_d = walking && last_phase;

    seg_valid_d = walking && seg_live;
    seg_idx_d   = walking ? phase_q : '0;
    seg_x_d     = walking ? base_x : '0;
    seg_y_d     = walking ? base_y : '0;

    done_d = done_pend_q;
    hit_d  = done_pend_q ? hit_acc_q : hit_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      qry_x_q     <= '0;
      qry_y_q     <= '0;
      len_q       <= '0;
      hit_acc_q   <= 1'b0;
      done_pend_q <= 1'b0;
      seg_valid_q <= 1'b0;
      seg_idx_q   <= '0;
      seg_x_q     <= '0;
      seg_y_q     <= '0;
      hit_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      qry_x_q     <= qry_x_d;
      qry_y_q     <= qry_y_d;
      len_q       <= len_d;
      hit_acc_q   <= hit_acc_d;
      done_pend_q <= done_pend_d;
      seg_valid_q <= seg_valid_d;
      seg_idx_q   <= seg_idx_d;
      seg_x_q     <= seg_x_d;
      seg_y_q     <= seg_y_d;
      hit_q       <= hit_d;
      done_q      <= done_d;
    end
  end

  assign o_phase0    = (phase_q == '0);
  assign o_busy      = (state_q != StIdle);
  assign o_seg_valid = seg_valid_q;
  assign o_seg_idx   = seg_idx_q;
  assign o_seg_x     = seg_x_q;
  assign o_seg_y     = seg_y_q;
  assign o_hit       = hit_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_snake_body_walker.sv
// Bench for snake_body_walker: table of directed passes, hand sequences for
// ignored restart and mid-walk reset, and random passes, all checked cycle by
// cycle against a reference that traces the body with modular arithmetic.
module tb_snake_body_walker;

  localparam int D  = 220;
  localparam int GW = 20;
  localparam int GH = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start;
  logic [4:0] i_head_x;
  logic [3:0] i_head_y;
  logic [7:0] i_length;
  logic [4:0] i_query_x;
  logic [3:0] i_query_y;
  logic [1:0] i_dir;
  logic       o_phase0, o_busy, o_seg_valid, o_hit, o_done;
  logic [7:0] o_seg_idx;
  logic [4:0] o_seg_x;
  logic [3:0] o_seg_y;

  snake_body_walker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_head_x    (i_head_x),
    .i_head_y    (i_head_y),
    .i_length    (i_length),
    .i_query_x   (i_query_x),
    .i_query_y   (i_query_y),
    .i_dir       (i_dir),
    .o_phase0    (o_phase0),
    .o_busy      (o_busy),
    .o_seg_valid (o_seg_valid),
    .o_seg_idx   (o_seg_idx),
    .o_seg_x     (o_seg_x),
    .o_seg_y     (o_seg_y),
    .o_hit       (o_hit),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  int         n_err = 0;
  int         n_chk = 0;
  int         phase = 0;
  int         prev_hit = 0;
  logic [1:0] ring [D];
  int         ex [D];
  int         ey [D];

  typedef struct {
    int pat;  // 0 all right, 1 all up, 2 right/down/left/up then right
    int hx, hy, len, qx, qy;
    int sph;  // phase to start at, -1 = start in the current cycle
    int hit;
    int s1x, s1y, s2x, s2y;  // expected segments 1 and 2, -1 = not live
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s t=%0t phase=%0d got=%0h want=%0h", name, $time, phase, got, want);
    end
  endtask

  task automatic step();
    logic r;
    r = rst_n;
    @(posedge clk);
    #1;
    phase = !r ? 0 : ((phase == D - 1) ? 0 : phase + 1);
    i_dir = ring[phase];
  endtask

  // Body trace from the head: segment k+1 is segment k minus move(slot k).
  task automatic build_model(input int hx, input int hy);
    ex[0] = hx;
    ey[0] = hy;
    for (int k = 1; k < D; k++) begin
      ex[k] = ex[k-1];
      ey[k] = ey[k-1];
      case (ring[k-1])
        2'd0: ex[k] = (ex[k-1] + GW - 1) % GW;
        2'd1: ey[k] = (ey[k-1] + GH - 1) % GH;
        2'd2: ex[k] = (ex[k-1] + 1) % GW;
        default: ey[k] = (ey[k-1] + 1) % GH;
      endcase
    end
  endtask

  function automatic int hit_of(input int len, input int qx, input int qy);
    int lim;
    lim = (len < D) ? len : D;
    for (int k = 1; k < lim; k++)
      if (ex[k] == qx && ey[k] == qy) return 1;
    return 0;
  endfunction

  task automatic chk_idle(input string name, input bit full);
    logic [21:0] got, want;
    got = {o_phase0, o_busy, o_seg_valid, o_done, o_hit, o_seg_idx, o_seg_x, o_seg_y};
    want = {(phase == 0), 1'b0, 1'b0, 1'b0, prev_hit[0], 17'd0};
    if (!full) got[16:0] = '0;
    chk(name, 32'(got), 32'(want));
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk_idle("idle_after", 1'b0);
    end
  endtask

  task automatic set_ring(input int pat);
    for (int i = 0; i < D; i++) begin
      case (pat)
        0: ring[i] = 2'd0;
        1: ring[i] = 2'd3;
        2: ring[i] = (i < 4) ? 2'(i) : 2'd0;
        default: ring[i] = 2'($urandom_range(0, 3));
      endcase
    end
    i_dir = ring[phase];
  endtask

  // One pass; returns in the o_done cycle (or after post-reset idle checks).
  task automatic run_pass(input int hx, input int hy, input int len, input int qx, input int qy,
                          input int sph, input int dup_k, input int rst_k,
                          output int got_hit, output int s1x, output int s1y,
                          output int s2x, output int s2y);
    int p, k0, lim, eh, k;
    logic busy_e, valid_e, done_e, hit_e;
    logic [16:0] seg_e;
    logic [21:0] got, want;
    build_model(hx, hy);
    eh = hit_of(len, qx, qy);
    lim = (len < D) ? len : D;
    got_hit = -1; s1x = -1; s1y = -1; s2x = -1; s2y = -1;
    if (sph >= 0)
      for (int w = 0; w < D && phase != sph; w++) step();
    p = phase;
    k0 = D - p;  // cycles from start request to the phase-0 walk cycle
    i_head_x = 5'(hx); i_head_y = 4'(hy); i_length = 8'(len);
    i_query_x = 5'(qx); i_query_y = 4'(qy);
    i_start = 1'b1;
    for (int c = 1; c <= k0 + D + 1; c++) begin
      step();
      i_start = 1'b0;
      k = c - k0 - 1;
      busy_e  = (c <= k0 + D - 1);
      valid_e = (k >= 0) && (k < D) && (k < lim);
      done_e  = (c == k0 + D + 1);
      hit_e   = done_e ? eh[0] : prev_hit[0];
      seg_e   = ((k >= 0) && (k < D)) ? {8'(k), 5'(ex[k]), 4'(ey[k])} : 17'd0;
      got  = {o_phase0, o_busy, o_seg_valid, o_done, o_hit, o_seg_idx, o_seg_x, o_seg_y};
      want = {(phase == 0), busy_e, valid_e, done_e, hit_e, seg_e};
      if (!((k >= 0) && (k < D))) got[16:0] = '0;
      chk("walk_cycle", 32'(got), 32'(want));
      if (k == 1 && o_seg_valid) begin s1x = int'(o_seg_x); s1y = int'(o_seg_y); end
      if (k == 2 && o_seg_valid) begin s2x = int'(o_seg_x); s2y = int'(o_seg_y); end
      if (done_e) got_hit = int'(o_hit);
      if (dup_k >= 0 && c == k0 + dup_k) i_start = 1'b1;
      if (rst_k >= 0 && c == k0 + rst_k) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        prev_hit = 0;
        chk_idle("reset_midwalk", 1'b1);
        idle_check(D + 4);
        return;
      end
    end
    prev_hit = eh;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_p0, gh, s1x, s1y, s2x, s2y, hx, hy, len, qx, qy, sph;

    tbl[0] = '{0, 10, 7,   4,  0,  0, 100, 0,  9, 7,  8,  7};
    tbl[1] = '{0,  1, 0,   3, 19,  0, 219, 1,  0, 0, 19,  0};
    tbl[2] = '{1,  0, 14,  2,  0, 14,   0, 0,  0, 0, -1, -1};
    tbl[3] = '{2,  5, 5,   5,  5,  5,   5, 1,  4, 5,  4,  4};
    tbl[4] = '{2,  5, 5,   4,  5,  5,  -1, 0,  4, 5,  4,  4};
    tbl[5] = '{0,  3, 3,   0,  2,  3, 217, 0, -1, -1, -1, -1};
    tbl[6] = '{0, 10, 7, 255, 10,  7,   1, 1,  9, 7,  8,  7};
    tbl[7] = '{0, 10, 7,  21, 10,  7,  30, 1,  9, 7,  8,  7};
    tbl[8] = '{0, 10, 7,  20, 10,  7,  -1, 0,  9, 7,  8,  7};

    rst_n = 1'b0; i_start = 1'b0;
    i_head_x = '0; i_head_y = '0; i_length = '0; i_query_x = '0; i_query_y = '0;
    set_ring(0);
    step();
    step();
    rst_n = 1'b1;

    // Idle after reset: phase-0 marker every D cycles, everything else low.
    n_p0 = 0;
    for (int i = 0; i < 3 * D; i++) begin
      chk_idle("reset_idle", 1'b1);
      if (o_phase0) n_p0++;
      step();
    end
    chk("phase0_count", 32'(n_p0), 32'd3);

    for (int t = 0; t < 9; t++) begin
      set_ring(tbl[t].pat);
      run_pass(tbl[t].hx, tbl[t].hy, tbl[t].len, tbl[t].qx, tbl[t].qy, tbl[t].sph, -1, -1,
               gh, s1x, s1y, s2x, s2y);
      chk($sformatf("tbl%0d_hit", t), 32'(gh), 32'(tbl[t].hit));
      if (tbl[t].s1x >= 0) chk($sformatf("tbl%0d_seg1", t), {s1x[15:0], s1y[15:0]},
                               {tbl[t].s1x[15:0], tbl[t].s1y[15:0]});
      if (tbl[t].s2x >= 0) chk($sformatf("tbl%0d_seg2", t), {s2x[15:0], s2y[15:0]},
                               {tbl[t].s2x[15:0], tbl[t].s2y[15:0]});
    end

    // Second start mid-walk is dropped: one o_done, then idle.
    set_ring(0);
    run_pass(10, 7, 4, 0, 0, 100, 50, -1, gh, s1x, s1y, s2x, s2y);
    chk("dup_start_hit", 32'(gh), 32'd0);
    idle_check(5);

    // Reset at walk phase 50: outputs clear, no o_done, phase restarts.
    set_ring(2);
    run_pass(5, 5, 5, 5, 5, 10, -1, 50, gh, s1x, s1y, s2x, s2y);

    for (int r = 0; r < 8; r++) begin
      set_ring(3);
      hx = $urandom_range(0, GW - 1);
      hy = $urandom_range(0, GH - 1);
      len = (r % 3 == 0) ? $urandom_range(0, 30) : $urandom_range(0, 255);
      build_model(hx, hy);
      if (r % 2 == 0) begin
        qx = $urandom_range(0, GW - 1);
        qy = $urandom_range(0, GH - 1);
      end else begin
        int pick;
        pick = $urandom_range(1, D - 1);
        qx = ex[pick];
        qy = ey[pick];
      end
      sph = (r % 3 == 2) ? -1 : $urandom_range(0, D - 1);
      run_pass(hx, hy, len, qx, qy, sph, -1, -1, gh, s1x, s1y, s2x, s2y);
      chk("rand_hit", 32'(gh), 32'(hit_of(len, qx, qy)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/snake_body_walker.md
Name: snake_body_walker

Overview:
- Reader end of the snake body ring: the 2-bit direction shift register, with its output fed back to its input, forms a DEPTH-slot loop.
- This block taps the loop output once per pass after a start request. It reconstructs each body segment's grid coordinate from the head position and the direction stream.
- Outputs: a per-segment stream for the renderer, plus a self-collision / query-hit flag and a phase-0 marker for the ring writer.

Parameters:
DEPTH, 220, slots in the direction ring (max body segments)
GRID_W, 20, playfield width in cells
GRID_H, 15, playfield height in cells
X_BITS, 5, x coordinate width (>= clog2(GRID_W))
Y_BITS, 4, y coordinate width (>= clog2(GRID_H))
LEN_BITS, 8, length width (>= clog2(DEPTH+1))

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
i_start  input  1  request one walk pass (single-cycle pulse)
i_head_x  input  X_BITS  head x, sampled at walk begin
i_head_y  input  Y_BITS  head y, sampled at walk begin
i_length  input  LEN_BITS  body length incl. head, sampled at walk begin
i_query_x  input  X_BITS  query cell x, sampled at walk begin
i_query_y  input  Y_BITS  query cell y, sampled at walk begin
i_dir  input  2  ring output tap (shift register o_data)
o_phase0  output  1  high in the cycle the ring slot 0 (newest) is on i_dir
o_busy  output  1  ARMED or WALK
o_seg_valid  output  1  o_seg_x/y is a live segment
o_seg_idx  output  LEN_BITS  segment index, 0 = head
o_seg_x  output  X_BITS  segment x
o_seg_y  output  Y_BITS  segment y
o_hit  output  1  query matched a segment with idx >= 1 during last pass
o_done  output  1  one-cycle pulse at end of pass

Behaviour:
- Direction encoding: 0 = +x, 1 = +y, 2 = -x, 3 = -y. Slot k holds the move taken from segment k+1 to segment k.
- Phase counter: 0..DEPTH-1, increments every cycle, wraps DEPTH-1 -> 0, reset to 0. o_phase0 = (phase == 0). The ring writer inserts relative to this counter, so i_dir at phase k is slot k.
- Reset values: state IDLE, phase 0, every output 0.
- IDLE: on i_start go to ARMED. If phase == DEPTH-1 in that cycle, ARMED is skipped and the walk begins at the next phase 0.
- ARMED: wait until phase == 0. In that cycle latch head/length/query, load cursor = head, clear the hit accumulator, enter WALK.
- WALK, each cycle with k = phase:
  - Emit o_seg_idx = k, o_seg_x/y = cursor, o_seg_valid = (k < L_eff), where L_eff = min(i_length, DEPTH).
  - Then update cursor = cursor minus move(i_dir), wrapping modulo GRID_W / GRID_H: x = 0 minus 1 -> GRID_W-1; x = GRID_W-1 plus 1 -> 0; same for y.
- Outputs are registered: segment k appears one cycle after phase k (latency 1 from tap).
- Hit: set when o_seg_valid, k >= 1, and cursor == query. Head vs query is excluded.
- End of pass: leaving WALK after phase DEPTH-1 returns to IDLE. o_done pulses in the cycle after the last segment output. o_hit updates at the o_done edge and holds until the next o_done.
- i_start while ARMED/WALK is ignored; no queueing.
- i_start in the same cycle as o_done is accepted.
- i_length = 0: no o_seg_valid, o_hit = 0, o_done still pulses.
- rst_n low mid-walk: next edge returns to IDLE, phase 0, all outputs 0, latched data discarded.

Decomposition:
- Shared package snake_pkg holds:
  - dir_t (2-bit enum DIR_RIGHT / DIR_DOWN / DIR_LEFT / DIR_UP)
  - GRID_W, GRID_H, DEPTH constants
  - pure function step_back(x, y, dir) with wrap
- One natural sub-module: snake_coord_stepper, the combinational wrap-aware coordinate decrement, reused by the head-update logic.
- Phase counter and FSM stay in snake_body_walker.

Test Plan:
- Reset then idle 3*DEPTH cycles -> o_phase0 exactly every 220 cycles; o_busy, o_seg_valid, o_done, o_hit all 0.
- Ring all DIR_RIGHT, head (10,7), length 4, start -> segments (10,7),(9,7),(8,7),(7,7) idx 0..3 valid; idx 4..219 invalid; o_done one cycle after idx 219; o_hit 0.
- Wrap: ring all DIR_RIGHT, head (1,0), length 3 -> (1,0),(0,0),(19,0); ring all DIR_UP, head (0,14), length 2 -> (0,14),(0,0).
- Self-hit: slots 0..3 = RIGHT, DOWN, LEFT, UP, head (5,5), length 5, query (5,5) -> idx 4 = (5,5), o_hit 1. Same with length 4 -> o_hit 0.
- Start when phase = 100 -> o_busy immediately; first valid output one cycle after phase 0; second i_start mid-walk ignored (single o_done); length 0 -> only o_done.
- rst_n low for 1 cycle at phase 50 of a walk -> outputs 0 next cycle, no o_done, phase restarts at 0.
